// File: rtl/spi_sys_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_sys_bridge_if
// Description : Core-side strobes and user-side buffer/status signals of the
//               SPI system-clock bridge, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_sys_bridge_if #(
    parameter int DATA_WDT = 8,
    parameter int CNT_WDT  = 16
);
    logic                spiSsel;
    logic                spiTxLoadFirst;
    logic                spiTxLoadNext;
    logic                spiRxRdy;
    logic [DATA_WDT-1:0] spiRxData;
    logic [DATA_WDT-1:0] spiTxData;
    logic                busy;
    logic                frameStart;
    logic                frameEnd;
    logic                rxValid;
    logic [DATA_WDT-1:0] rxWord;
    logic [CNT_WDT-1:0]  wordCnt;
    logic                txWr;
    logic [DATA_WDT-1:0] txDin;
    logic                txFull;
    logic                txReq;
    logic                txUnderrun;
    logic                txOverflow;
    logic                errClr;

    // The bridge itself
    modport slave (
        input  spiSsel, spiTxLoadFirst, spiTxLoadNext, spiRxRdy, spiRxData,
        input  txWr, txDin, errClr,
        output spiTxData, busy, frameStart, frameEnd, rxValid, rxWord,
        output wordCnt, txFull, txReq, txUnderrun, txOverflow
    );

    // Core plus user logic driving the bridge
    modport master (
        output spiSsel, spiTxLoadFirst, spiTxLoadNext, spiRxRdy, spiRxData,
        output txWr, txDin, errClr,
        input  spiTxData, busy, frameStart, frameEnd, rxValid, rxWord,
        input  wordCnt, txFull, txReq, txUnderrun, txOverflow
    );
endinterface
`default_nettype wire

// File: rtl/spi_sys_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sys_bridge
// Description : Resynchronises SPI slave core strobes into clk, captures
//               received words and feeds the core from a 2-deep TX buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sys_bridge #(
    parameter int DATA_WDT    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WDT     = 16
) (
    input  logic              clk,
    input  logic              reset,
    spi_sys_bridge_if.slave   bus
);
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_ssel_sh, r_lf_sh, r_ln_sh, r_rx_sh;
    logic                   r_ssel_prev, r_lf_prev, r_ln_prev, r_rx_prev;

    logic                   r_frame_start, r_frame_end, r_rx_valid, r_cand;
    logic [DATA_WDT-1:0]    r_stage, r_rx_word;
    logic [CNT_WDT-1:0]     r_word_cnt;

    logic [DATA_WDT-1:0]    r_tx_data, r_pend;
    logic                   r_fresh, r_pend_v, r_tx_req, r_under, r_over;

    logic                   w_ssel_s, w_lf_s, w_ln_s, w_rx_s;
    logic                   w_ssel_fall, w_ssel_rise, w_rx_fall, w_load;
    logic                   w_fresh_l, w_pendv_l, w_ovf, w_unf;
    logic [DATA_WDT-1:0]    w_data_l;

    // Synchronisers; ssel idles high, strobes idle low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ssel_sh   <= '1;
            r_lf_sh     <= '0;
            r_ln_sh     <= '0;
            r_rx_sh     <= '0;
            r_ssel_prev <= 1'b1;
            r_lf_prev   <= 1'b0;
            r_ln_prev   <= 1'b0;
            r_rx_prev   <= 1'b0;
        end else begin
            r_ssel_sh   <= {r_ssel_sh[SYNC_STAGES-2:0], bus.spiSsel};
            r_lf_sh     <= {r_lf_sh[SYNC_STAGES-2:0], bus.spiTxLoadFirst};
            r_ln_sh     <= {r_ln_sh[SYNC_STAGES-2:0], bus.spiTxLoadNext};
            r_rx_sh     <= {r_rx_sh[SYNC_STAGES-2:0], bus.spiRxRdy};
            r_ssel_prev <= w_ssel_s;
            r_lf_prev   <= w_lf_s;
            r_ln_prev   <= w_ln_s;
            r_rx_prev   <= w_rx_s;
        end
    end

    assign w_ssel_s    = r_ssel_sh[SYNC_STAGES-1];
    assign w_lf_s      = r_lf_sh[SYNC_STAGES-1];
    assign w_ln_s      = r_ln_sh[SYNC_STAGES-1];
    assign w_rx_s      = r_rx_sh[SYNC_STAGES-1];
    assign w_ssel_fall = r_ssel_prev & ~w_ssel_s;
    assign w_ssel_rise = ~r_ssel_prev & w_ssel_s;
    assign w_rx_fall   = r_rx_prev & ~w_rx_s;
    assign w_load      = (~r_lf_prev & w_lf_s) | (~r_ln_prev & w_ln_s);

    // Frame FSM and receive path; a staged word commits one cycle later
    // unless ssel rose meanwhile (core reset on abort fakes an rxRdy fall).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_cand        <= 1'b0;
            r_stage       <= '0;
            r_rx_word     <= '0;
            r_word_cnt    <= '0;
        end else begin
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_cand        <= w_rx_fall && (r_state == S_ACTIVE);
            if (w_rx_fall && (r_state == S_ACTIVE)) begin
                r_stage <= bus.spiRxData;
            end
            if (r_cand && !w_ssel_rise && (r_state == S_ACTIVE)) begin
                r_rx_word  <= r_stage;
                r_rx_valid <= 1'b1;
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_ssel_fall) begin
                        r_state       <= S_ACTIVE;
                        r_frame_start <= 1'b1;
                        r_word_cnt    <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (w_ssel_rise) begin
                        r_state     <= S_IDLE;
                        r_frame_end <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Buffer state after the load, before any same-cycle write
    always_comb begin
        w_fresh_l = r_fresh;
        w_pendv_l = r_pend_v;
        w_data_l  = r_tx_data;
        if (w_load) begin
            w_fresh_l = r_pend_v;
            w_pendv_l = 1'b0;
            if (r_pend_v) begin
                w_data_l = r_pend;
            end
        end
    end

    assign w_ovf = bus.txWr & w_fresh_l & w_pendv_l;
    assign w_unf = w_load & ~r_fresh;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_data <= '0;
            r_pend    <= '0;
            r_fresh   <= 1'b0;
            r_pend_v  <= 1'b0;
            r_tx_req  <= 1'b0;
            r_under   <= 1'b0;
            r_over    <= 1'b0;
        end else begin
            r_tx_req  <= w_load;
            r_tx_data <= w_data_l;
            r_fresh   <= w_fresh_l;
            r_pend_v  <= w_pendv_l;
            if (bus.txWr) begin
                if (!w_fresh_l) begin
                    r_tx_data <= bus.txDin;
                    r_fresh   <= 1'b1;
                end else if (!w_pendv_l) begin
                    r_pend    <= bus.txDin;
                    r_pend_v  <= 1'b1;
                end
            end
            r_under <= w_unf | (r_under & ~bus.errClr);
            r_over  <= w_ovf | (r_over & ~bus.errClr);
        end
    end

    assign bus.spiTxData  = r_tx_data;
    assign bus.busy       = (r_state == S_ACTIVE);
    assign bus.frameStart = r_frame_start;
    assign bus.frameEnd   = r_frame_end;
    assign bus.rxValid    = r_rx_valid;
    assign bus.rxWord     = r_rx_word;
    assign bus.wordCnt    = r_word_cnt;
    assign bus.txFull     = r_fresh & r_pend_v;
    assign bus.txReq      = r_tx_req;
    assign bus.txUnderrun = r_under;
    assign bus.txOverflow = r_over;
endmodule
`default_nettype wire
